// File: rtl/sap_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sap_ram_pkg
// Brief    : Shared SAP widths and the program-loader state encoding.
// Revision : 1.0
// ============================================================================
package sap_ram_pkg;

    localparam int SAP_ADDR_W = 8;
    localparam int SAP_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/sap_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : sap_ram_loader
// Brief    : Byte-stream program loader; assembles hi/lo bytes into words
//            written upward from address 0 through a single write port.
// Revision : 1.0
// ============================================================================
module sap_ram_loader
    import sap_ram_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [7:0]        prog_byte,
    output logic              prog_ready,
    output logic [ADDR_W:0]   prog_words,
    output logic              prog_done,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W:0]   c_WORDS_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_t       r_state;
    logic              r_ready;
    logic              r_done;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_hi;
    logic [7:0]        r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_words <= '0;
            r_addr  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (prog_mode) begin
                        r_state <= ST_LOAD_HI;
                        r_ready <= 1'b1;
                        r_addr  <= '0;
                        r_words <= '0;
                    end
                end
                ST_LOAD_HI: begin
                    if (!prog_mode) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end else if (prog_valid && r_ready) begin
                        r_hi    <= prog_byte;
                        r_state <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (!prog_mode) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end else if (prog_valid && r_ready) begin
                        r_lo    <= prog_byte;
                        r_state <= ST_WRITE;
                        r_ready <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // The assembled word is committed this cycle even if prog_mode drops.
                    if (r_words != c_WORDS_MAX) begin
                        r_words <= r_words + 1'b1;
                    end
                    if (!prog_mode) begin
                        r_state <= ST_IDLE;
                    end else if (r_addr == c_LAST_ADDR) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= ST_LOAD_HI;
                        r_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!prog_mode) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ready = r_ready;
    assign prog_words = r_words;
    assign prog_done  = r_done;
    assign busy       = (r_state != ST_IDLE);
    assign wr_en      = (r_state == ST_WRITE);
    assign wr_addr    = r_addr;
    assign wr_data    = {r_hi, r_lo};

endmodule
`default_nettype wire

// File: rtl/sap_ram.sv
`default_nettype none
// ============================================================================
// Module   : sap_ram
// Brief    : SAP main memory with registered read port and program loader.
// Revision : 1.0
// ============================================================================
module sap_ram
    import sap_ram_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ram_write,
    input  logic              ram_read,
    output logic [DATA_W-1:0] ram_out,
    output logic              ram_out_en,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [7:0]        prog_byte,
    output logic              prog_ready,
    output logic [ADDR_W:0]   prog_words,
    output logic              prog_done
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_out;
    logic              r_out_en;

    logic              w_ld_busy;
    logic              w_ld_we;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_normal;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    sap_ram_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_byte  (prog_byte),
        .prog_ready (prog_ready),
        .prog_words (prog_words),
        .prog_done  (prog_done),
        .busy       (w_ld_busy),
        .wr_en      (w_ld_we),
        .wr_addr    (w_ld_addr),
        .wr_data    (w_ld_data)
    );

    // Bus-side access only while the loader is idle and not being requested.
    assign w_normal = !w_ld_busy && !prog_mode;
    assign w_we     = !rst && (w_ld_we || (w_normal && ram_write));
    assign w_waddr  = w_ld_we ? w_ld_addr : mar_addr;
    assign w_wdata  = w_ld_we ? w_ld_data : bus_in;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_out_en <= 1'b0;
        end else if (w_normal && ram_read) begin
            r_out    <= r_mem[mar_addr];
            r_out_en <= 1'b1;
        end else begin
            r_out_en <= 1'b0;
        end
    end

    assign ram_out    = r_out;
    assign ram_out_en = r_out_en;

endmodule
`default_nettype wire

// File: tb/tb_sap_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_ram
// Brief    : Self-checking bench for sap_ram (vectors, random model, loader).
// Revision : 1.0
// ============================================================================
module tb_sap_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mar_addr = '0;
    logic [15:0] bus_in = '0;
    logic        ram_write = 1'b0;
    logic        ram_read = 1'b0;
    logic [15:0] ram_out;
    logic        ram_out_en;
    logic        prog_mode = 1'b0;
    logic        prog_valid = 1'b0;
    logic [7:0]  prog_byte = '0;
    logic        prog_ready;
    logic [8:0]  prog_words;
    logic        prog_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sap_ram dut (
        .clk        (clk),
        .rst        (rst),
        .mar_addr   (mar_addr),
        .bus_in     (bus_in),
        .ram_write  (ram_write),
        .ram_read   (ram_read),
        .ram_out    (ram_out),
        .ram_out_en (ram_out_en),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_byte  (prog_byte),
        .prog_ready (prog_ready),
        .prog_words (prog_words),
        .prog_done  (prog_done)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_out;
        logic        exp_en;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
        ram_read = 1'b1;
        mar_addr = a;
        tick();
        ram_read = 1'b0;
        chk({name, "_en"}, {31'd0, ram_out_en}, 32'd1);
        chk(name, {16'd0, ram_out}, {16'd0, exp});
    endtask

    // Waits (bounded) for prog_ready, then presents one byte for one cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        prog_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        waited = 0;
        while (!prog_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!prog_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got prog_ready=0 expected 1");
        end
        prog_valid = 1'b1;
        prog_byte  = b;
        tick();
        prog_valid = 1'b0;
    endtask

    vec_t        vecs[8];
    logic [15:0] ref_mem   [256];
    bit          ref_known [256];

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        logic        wr, rd;
        logic [15:0] exp_out;
        logic        exp_out_known;
        logic        exp_en;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_out",   {16'd0, ram_out},    32'd0);
        chk("rst_en",    {31'd0, ram_out_en}, 32'd0);
        chk("rst_ready", {31'd0, prog_ready}, 32'd0);
        chk("rst_done",  {31'd0, prog_done},  32'd0);
        chk("rst_words", {23'd0, prog_words}, 32'd0);
        rst = 1'b0;

        // ---------------- table-driven normal mode ----------------
        vecs[0] = '{wr:1, rd:0, addr:8'h10, data:16'hBEEF, exp_out:16'h0000, exp_en:0};
        vecs[1] = '{wr:0, rd:1, addr:8'h10, data:16'h0000, exp_out:16'hBEEF, exp_en:1};
        vecs[2] = '{wr:0, rd:0, addr:8'h10, data:16'h0000, exp_out:16'hBEEF, exp_en:0};
        vecs[3] = '{wr:1, rd:0, addr:8'h20, data:16'h1111, exp_out:16'hBEEF, exp_en:0};
        vecs[4] = '{wr:1, rd:1, addr:8'h20, data:16'h2222, exp_out:16'h1111, exp_en:1};
        vecs[5] = '{wr:0, rd:1, addr:8'h20, data:16'h0000, exp_out:16'h2222, exp_en:1};
        vecs[6] = '{wr:0, rd:1, addr:8'h10, data:16'h0000, exp_out:16'hBEEF, exp_en:1};
        vecs[7] = '{wr:0, rd:0, addr:8'h00, data:16'h0000, exp_out:16'hBEEF, exp_en:0};
        for (int i = 0; i < 8; i++) begin
            ram_write = vecs[i].wr;
            ram_read  = vecs[i].rd;
            mar_addr  = vecs[i].addr;
            bus_in    = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_out", i), {16'd0, ram_out},    {16'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d_en", i),  {31'd0, ram_out_en}, {31'd0, vecs[i].exp_en});
        end
        ram_write = 1'b0;
        ram_read  = 1'b0;

        // ---------------- randomized normal mode vs. model ----------------
        exp_out       = ram_out;
        exp_out_known = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a  = 8'h40 + 8'($urandom_range(0, 15));
            d  = 16'($urandom);
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            ram_write = wr;
            ram_read  = rd;
            mar_addr  = a;
            bus_in    = d;
            tick();
            if (rd) begin
                exp_en        = 1'b1;
                exp_out       = ref_mem[a];
                exp_out_known = ref_known[a];
            end else begin
                exp_en = 1'b0;
            end
            if (wr) begin
                ref_mem[a]   = d;
                ref_known[a] = 1'b1;
            end
            chk("rand_en", {31'd0, ram_out_en}, {31'd0, exp_en});
            if (exp_out_known) chk("rand_out", {16'd0, ram_out}, {16'd0, exp_out});
        end
        ram_write = 1'b0;
        ram_read  = 1'b0;

        // ---------------- loader partial stream with gaps ----------------
        prog_mode = 1'b1;
        tick();
        chk("entry_ready", {31'd0, prog_ready}, 32'd1);
        ram_read = 1'b1;
        mar_addr = 8'h10;
        tick();
        ram_read = 1'b0;
        chk("prog_read_blocked", {31'd0, ram_out_en}, 32'd0);
        send_byte(8'h12, 2);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 3);
        send_byte(8'hCD, 1);
        tick();
        chk("partial_words", {23'd0, prog_words}, 32'd2);
        prog_mode = 1'b0;
        tick();
        chk("partial_idle_ready", {31'd0, prog_ready}, 32'd0);
        chk("partial_words_hold", {23'd0, prog_words}, 32'd2);
        read_chk("partial_mem0", 8'h00, 16'h1234);
        read_chk("partial_mem1", 8'h01, 16'hABCD);

        // ---------------- abort after one byte ----------------
        prog_mode = 1'b1;
        tick();
        send_byte(8'h55, 0);
        prog_mode = 1'b0;
        tick();
        chk("abort_ready", {31'd0, prog_ready}, 32'd0);
        chk("abort_words", {23'd0, prog_words}, 32'd0);
        read_chk("abort_mem0", 8'h00, 16'h1234);

        // ---------------- full 256-word load ----------------
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0);
            send_byte(~8'(i), 0);
        end
        tick();
        chk("full_done",  {31'd0, prog_done},  32'd1);
        chk("full_words", {23'd0, prog_words}, 32'd256);
        chk("full_ready", {31'd0, prog_ready}, 32'd0);
        prog_valid = 1'b1;
        prog_byte  = 8'hEE;
        tick();
        tick();
        prog_valid = 1'b0;
        chk("full_extra_words", {23'd0, prog_words}, 32'd256);
        prog_mode = 1'b0;
        tick();
        chk("full_exit_done",  {31'd0, prog_done},  32'd0);
        chk("full_exit_words", {23'd0, prog_words}, 32'd256);
        read_chk("full_mem255", 8'hFF, 16'hFF00);
        read_chk("full_mem0",   8'h00, 16'h00FF);
        read_chk("full_mem100", 8'd100, 16'h649B);

        // ---------------- reset in the middle of a load ----------------
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            send_byte(~8'(i), 0);
            send_byte(8'(i), 0);
        end
        send_byte(8'hA5, 0);
        rst       = 1'b1;
        prog_mode = 1'b0;
        tick();
        rst = 1'b0;
        chk("mrst_ready", {31'd0, prog_ready}, 32'd0);
        chk("mrst_words", {23'd0, prog_words}, 32'd0);
        chk("mrst_done",  {31'd0, prog_done},  32'd0);
        chk("mrst_en",    {31'd0, ram_out_en}, 32'd0);
        tick();
        chk("mrst_stay_idle", {31'd0, prog_ready}, 32'd0);
        read_chk("mrst_mem0",   8'd0,   16'hFF00);
        read_chk("mrst_mem50",  8'd50,  16'hCD32);
        read_chk("mrst_mem99",  8'd99,  16'h9C63);
        read_chk("mrst_mem100", 8'd100, 16'h649B);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
